// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the pipeline port, the debug-loader port, the single-port
//            data-memory drive and the busy flag of mem_port_arbiter.
// Ports    : slave  - arbiter side (consumes requests, drives the memory)
//            master - environment side (issues requests, returns mem_rdata)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    // Pipeline MEM-stage port
    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [DW-1:0] p_rdata;
    logic          p_done;
    logic          p_stall;

    // Debug-loader port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;

    // Single-port memory drive
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_rdata, p_done, p_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_done,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_rdata, p_done, p_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port data memory between the CPU pipeline
//            MEM stage and a debug loader. Each access takes three cycles
//            (IDLE -> ACCESS -> RESP). The pipeline has priority, but after
//            STARVE_MAX consecutive pipeline grants with debug waiting, debug
//            is granted once.
// Ports    : clk        - single clock, rising edge
//            rst        - synchronous active-high reset
//            bus.slave  - pipeline port, debug port, memory drive, busy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int              c_cnt_w      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_grant_dbg;   // 1: debug owns the current access
    logic                 r_we;
    logic                 r_mem_we;
    logic [AW-1:0]        r_addr;
    logic [DW-1:0]        r_wdata;
    logic [c_cnt_w-1:0]   r_starve;
    logic [DW-1:0]        r_p_rdata;
    logic [DW-1:0]        r_d_rdata;
    logic                 r_p_done;
    logic                 r_d_done;

    logic                 w_any_req;
    logic                 w_starve_hit;
    logic                 w_dbg_wins;
    logic                 w_win_we;
    logic [AW-1:0]        w_win_addr;
    logic [DW-1:0]        w_win_wdata;

    // Winner selection; only consumed while in IDLE.
    always_comb begin
        w_any_req    = bus.p_req | bus.d_req;
        w_starve_hit = (r_starve == c_starve_max);
        w_dbg_wins   = bus.d_req & (~bus.p_req | w_starve_hit);
        w_win_we     = w_dbg_wins ? bus.d_we    : bus.p_we;
        w_win_addr   = w_dbg_wins ? bus.d_addr  : bus.p_addr;
        w_win_wdata  = w_dbg_wins ? bus.d_wdata : bus.p_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant_dbg <= 1'b0;
            r_we        <= 1'b0;
            r_mem_we    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_starve    <= '0;
            r_p_rdata   <= '0;
            r_d_rdata   <= '0;
            r_p_done    <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_p_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_ACCESS;
                        r_grant_dbg <= w_dbg_wins;
                        r_we        <= w_win_we;
                        r_mem_we    <= w_win_we;
                        r_addr      <= w_win_addr;
                        r_wdata     <= w_win_wdata;
                    end
                    // The counter measures how long debug has been passed
                    // over; it only advances on a pipeline grant that debug
                    // lost, and saturates rather than wrapping.
                    if (!bus.d_req || w_dbg_wins) begin
                        r_starve <= '0;
                    end else if (bus.p_req && !w_starve_hit) begin
                        r_starve <= r_starve + c_cnt_w'(1);
                    end
                end
                ST_ACCESS: begin
                    r_state  <= ST_RESP;
                    r_mem_we <= 1'b0;
                    if (r_grant_dbg) begin
                        r_d_done <= 1'b1;
                    end else begin
                        r_p_done <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    // mem_rdata is valid now, one cycle after the address.
                    if (!r_we) begin
                        if (r_grant_dbg) begin
                            r_d_rdata <= bus.mem_rdata;
                        end else begin
                            r_p_rdata <= bus.mem_rdata;
                        end
                    end
                    // Clearing here keeps the memory bus at zero in IDLE.
                    r_addr  <= '0;
                    r_wdata <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.p_rdata   = r_p_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.p_done    = r_p_done;
    assign bus.d_done    = r_d_done;
    assign bus.p_stall   = bus.p_req & ~r_p_done;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A transaction-level
//            reference model (grant cycle, winner, starvation run length and
//            a shadow memory) predicts every output each cycle; directed
//            scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous single-port memory: read data one cycle after address.
    logic [DW-1:0] mem_array [256];
    always @(posedge clk) begin
        bus.mem_rdata <= mem_array[bus.mem_addr];
        if (bus.mem_we) mem_array[bus.mem_addr] = bus.mem_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    int            cyc = 0;
    bit            g_valid = 1'b0;
    int            g_cyc = 0;
    bit            cur_dbg, cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    int            p_row = 0;          // pipeline wins while debug waited
    logic [DW-1:0] exp_p_rdata = '0;
    logic [DW-1:0] exp_d_rdata = '0;
    logic [DW-1:0] model_ram [256];
    bit            last_pdone = 1'b0;
    bit            last_ddone = 1'b0;
    byte           grant_q[$];         // order of done pulses seen from DUT
    bit            p_pend = 1'b0;
    bit            d_pend = 1'b0;

    // One cycle: check outputs against the model, then advance the model
    // through the clock edge using the inputs present in this cycle.
    task automatic step();
        bit in_acc, in_resp, e_pdone, e_ddone, dbg;
        @(negedge clk);
        in_acc  = g_valid && (cyc == g_cyc + 1);
        in_resp = g_valid && (cyc == g_cyc + 2);
        e_pdone = in_resp && !cur_dbg;
        e_ddone = in_resp &&  cur_dbg;
        check_val("busy",      32'(bus.busy),      32'(in_acc || in_resp));
        check_val("mem_we",    32'(bus.mem_we),    32'(in_acc && cur_we));
        check_val("mem_addr",  32'(bus.mem_addr),  (in_acc || in_resp) ? 32'(cur_addr)  : 32'd0);
        check_val("mem_wdata", 32'(bus.mem_wdata), (in_acc || in_resp) ? 32'(cur_wdata) : 32'd0);
        check_val("p_done",    32'(bus.p_done),    32'(e_pdone));
        check_val("d_done",    32'(bus.d_done),    32'(e_ddone));
        check_val("p_stall",   32'(bus.p_stall),   32'(bus.p_req && !e_pdone));
        check_val("p_rdata",   32'(bus.p_rdata),   32'(exp_p_rdata));
        check_val("d_rdata",   32'(bus.d_rdata),   32'(exp_d_rdata));
        if (bus.p_done === 1'b1) grant_q.push_back(8'h50);
        if (bus.d_done === 1'b1) grant_q.push_back(8'h44);
        last_pdone = e_pdone;
        last_ddone = e_ddone;

        if (rst) begin
            g_valid     = 1'b0;
            p_row       = 0;
            exp_p_rdata = '0;
            exp_d_rdata = '0;
        end else begin
            if (in_resp && !cur_we) begin
                if (cur_dbg) exp_d_rdata = model_ram[cur_addr];
                else         exp_p_rdata = model_ram[cur_addr];
            end
            if (!in_acc && !in_resp) begin
                if (bus.p_req || bus.d_req) begin
                    dbg       = bus.d_req && (!bus.p_req || p_row == SM);
                    cur_dbg   = dbg;
                    cur_we    = dbg ? bus.d_we    : bus.p_we;
                    cur_addr  = dbg ? bus.d_addr  : bus.p_addr;
                    cur_wdata = dbg ? bus.d_wdata : bus.p_wdata;
                    g_valid   = 1'b1;
                    g_cyc     = cyc;
                    if (cur_we) model_ram[cur_addr] = cur_wdata;
                    if (dbg) p_row = 0;
                    else if (bus.d_req && p_row < SM) p_row++;
                end
                if (!bus.d_req) p_row = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Requesters that follow the hold-until-done protocol, occasionally
    // dropping their request after being granted.
    task automatic drive_random(input int pp, input int pd);
        if (last_pdone) begin p_pend = 1'b0; bus.p_req = 1'b0; end
        if (!p_pend && $urandom_range(99) < pp) begin
            p_pend      = 1'b1;
            bus.p_req   = 1'b1;
            bus.p_we    = 1'($urandom_range(1));
            bus.p_addr  = AW'($urandom_range(15));
            bus.p_wdata = DW'($urandom);
        end else if (p_pend && g_valid && !cur_dbg && cyc == g_cyc + 1 && $urandom_range(9) == 0) begin
            bus.p_req = 1'b0;
        end
        if (last_ddone) begin d_pend = 1'b0; bus.d_req = 1'b0; end
        if (!d_pend && $urandom_range(99) < pd) begin
            d_pend      = 1'b1;
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom_range(1));
            bus.d_addr  = AW'($urandom_range(15));
            bus.d_wdata = DW'($urandom);
        end else if (d_pend && g_valid && cur_dbg && cyc == g_cyc + 1 && $urandom_range(9) == 0) begin
            bus.d_req = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string pat;
        pat = "PPPPDPPPPD";
        for (int i = 0; i < 256; i++) begin
            mem_array[i] = DW'((i * 16'h0101) ^ 16'h5A5A);
            model_ram[i] = DW'((i * 16'h0101) ^ 16'h5A5A);
        end
        mem_array[5] = 16'h1234;
        model_ram[5] = 16'h1234;
        bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state
        @(posedge clk); #1;
        run(2);
        rst = 1'b0;
        run(1);

        // Pipeline read of 0x05
        bus.p_req = 1; bus.p_we = 0; bus.p_addr = 8'h05;
        run(3);
        bus.p_req = 0;
        run(2);
        check_val("pipe_read_rdata", 32'(bus.p_rdata), 32'h1234);

        // Debug write 0xBEEF to 0x10
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h10; bus.d_wdata = 16'hBEEF;
        run(3);
        bus.d_req = 0;
        run(2);
        check_val("dbg_write_mem", 32'(mem_array[16]), 32'hBEEF);
        check_val("dbg_write_prdata_kept", 32'(bus.p_rdata), 32'h1234);

        // Simultaneous single requests: pipeline first, debug next
        grant_q.delete();
        bus.p_req = 1; bus.p_we = 0; bus.p_addr = 8'h03;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h07;
        run(3);
        bus.p_req = 0;
        run(3);
        bus.d_req = 0;
        run(1);
        check_val("simul_count", 32'(grant_q.size()), 32'd2);
        if (grant_q.size() == 2) begin
            check_val("simul_first",  32'(grant_q[0]), 32'h50);
            check_val("simul_second", 32'(grant_q[1]), 32'h44);
        end

        // Reset during ACCESS of a write
        bus.p_req = 1; bus.p_we = 1; bus.p_addr = 8'h20; bus.p_wdata = 16'hCAFE;
        run(1);
        rst = 1'b1;
        run(1);
        rst = 1'b0; bus.p_req = 0;
        run(2);
        check_val("rst_abort_prdata", 32'(bus.p_rdata), 32'd0);

        // Continuous contention
        grant_q.delete();
        bus.p_req = 1; bus.p_we = 0; bus.p_addr = 8'h01;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h02;
        run(30);
        bus.p_req = 0; bus.d_req = 0;
        run(3);
        check_val("contention_count", 32'(grant_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < grant_q.size(); i++) begin
            check_val($sformatf("contention_grant%0d", i), 32'(grant_q[i]), 32'(pat[i]));
        end

        // Randomized traffic
        last_pdone = 1'b0; last_ddone = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            drive_random(45, 35);
            step();
        end
        bus.p_req = 0; bus.d_req = 0;
        run(6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 8, data-memory address width.
REQ-002 Parameter DW, default 16, data-memory data width.
REQ-003 Parameter STARVE_MAX, default 4, max consecutive pipeline grants while debug waits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 p_req / p_we  input  1 / 1  pipeline MEM-stage access request / write qualifier.
REQ-007 p_addr / p_wdata  input  AW / DW  pipeline address / write data.
REQ-008 p_rdata / p_done / p_stall  output  DW / 1 / 1  pipeline read data / completion pulse / stall request.
REQ-009 d_req / d_we  input  1 / 1  debug-loader request / write qualifier.
REQ-010 d_addr / d_wdata  input  AW / DW  debug address / write data.
REQ-011 d_rdata / d_done  output  DW / 1  debug read data / completion pulse.
REQ-012 mem_addr / mem_wdata / mem_we  output  AW / DW / 1  single-port memory drive.
REQ-013 mem_rdata  input  DW  memory read data, valid the cycle after mem_addr is presented.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when p_req|d_req, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016 Arbitration only in IDLE: winner's we/addr/wdata and winner id registered at the IDLE->ACCESS edge.
REQ-017 Default priority pipeline over debug.
REQ-018 Starvation counter (width clog2(STARVE_MAX+1)) increments on each pipeline grant made while d_req=1; cleared on debug grant or any IDLE cycle with d_req=0.
REQ-019 When counter == STARVE_MAX and d_req=1, debug wins the next arbitration even if p_req=1.
REQ-020 mem_addr/mem_wdata driven from registered values during ACCESS and RESP; 0 in IDLE.
REQ-021 mem_we = 1 for exactly one cycle (ACCESS) for a write grant; 0 otherwise.
REQ-022 In RESP, mem_rdata latched into winner's rdata register (reads only); loser's rdata unchanged; rdata holds until next read completion for that requester.
REQ-023 p_done/d_done: registered, high only during RESP, only for the winner; one cycle wide.
REQ-024 Latency: request sampled in IDLE at edge t -> done high in cycle t+2; throughput one access per 3 cycles.
REQ-025 Requester holds req and its operands stable until it sees done; requests seen during ACCESS/RESP are ignored.
REQ-026 p_stall = p_req & ~p_done (combinational).
REQ-027 Simultaneous p_req and d_req in IDLE: resolved per REQ-017/REQ-019; loser stays pending, served in the next IDLE.
REQ-028 Counter saturates at STARVE_MAX; never wraps.
REQ-029 Request dropped before done: transaction still completes; done pulse still issued.

Reset
REQ-030 rst=1 at an edge: state IDLE, counter 0, p_rdata=d_rdata=0, p_done=d_done=0, mem_we=0, mem_addr=mem_wdata=0, busy=0.
REQ-031 rst during ACCESS or RESP aborts transaction: no done pulse, mem_we low from next cycle.
REQ-032 rst dominates all requests in the same cycle.

Verification
REQ-033 Pipeline read: p_req=1,p_we=0,p_addr=0x05, mem returns 0x1234 -> p_done in cycle t+2, p_rdata=0x1234, mem_we never high.
REQ-034 Debug write: d_req=1,d_we=1,d_addr=0x10,d_wdata=0xBEEF -> mem_we high one cycle with mem_addr=0x10, mem_wdata=0xBEEF; d_done at t+2; p_rdata unchanged.
REQ-035 Contention: p_req and d_req held high continuously -> grants P,P,P,P,D,P,P,P,P,D (STARVE_MAX=4); each done exactly one cycle.
REQ-036 Simultaneous single requests p_req=d_req=1, counter 0 -> pipeline served first (done t+2), debug served next (done t+5).
REQ-037 rst asserted during ACCESS of a write -> mem_we 0 next cycle, no done, all outputs at reset values, counter 0.
REQ-038 p_stall: p_req=1 from IDLE -> p_stall=1 for cycles t, t+1, 0 in t+2.
